// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM encodings, default
// timing parameters and small width helpers.
package song_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_FADE = 2'd2
   } state_t;

   localparam int         DEF_FRAMES_PER_STEP = 7;
   localparam int         DEF_ARP_FRAMES      = 4;
   localparam logic [7:0] DEF_LOOP_POS        = 8'd64;
   localparam int         DEF_ENV_W           = 4;

   // Full-scale value of a w-bit envelope.
   function automatic int env_max(input int w);
      return (1 << w) - 1;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/song_sequencer_trig_env.sv
// Drum envelope register (trig_env): loads full scale when triggered at a
// step, otherwise decays by one per enabled frame and rests at zero.
module song_sequencer_trig_env
   import song_sequencer_pkg::*;
#(
   parameter int ENV_W = DEF_ENV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic             load_en,
   input  logic             dec_en,
   output logic [ENV_W-1:0] env
);

   localparam logic [ENV_W-1:0] ENV_MAX = ENV_W'(env_max(ENV_W));

   logic [ENV_W-1:0] r_env;

   // Load takes priority over decay; decay saturates at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_env <= '0;
      end else if (load_en && trig) begin
         r_env <= ENV_MAX;
      end else if (dec_en && (r_env != '0)) begin
         r_env <= r_env - 1'b1;
      end
   end

   assign env = r_env;

endmodule

// File: rtl/song_sequencer.sv
// Playback timebase: counts frame ticks into song steps, drives the song ROM
// address and arpeggio select, and turns ROM drum triggers into envelopes.
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter int         FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
   parameter int         ARP_FRAMES      = DEF_ARP_FRAMES,
   parameter logic [7:0] LOOP_POS        = DEF_LOOP_POS,
   parameter int         ENV_W           = DEF_ENV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_tick,
   input  logic             start,
   input  logic             stop,
   input  logic             kick_in,
   input  logic             snare_in,
   input  logic             pulse_in,
   output logic [7:0]       songpos,
   output logic             arpidx,
   output logic             step_strobe,
   output logic [ENV_W-1:0] kick_env,
   output logic [ENV_W-1:0] snare_env,
   output logic             pulse_gate,
   output logic             playing
);

   localparam int              FCNT_W     = cnt_width(FRAMES_PER_STEP);
   localparam int              ACNT_W     = cnt_width(ARP_FRAMES);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_STEP - 1);
   localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ARP_FRAMES - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [FCNT_W-1:0]   r_fcnt;
   logic [ACNT_W-1:0]   r_acnt;
   logic [7:0]          r_songpos;
   logic                r_arpidx;
   logic                r_step_strobe;
   logic                r_pulse_gate;
   logic [ENV_W-1:0]    w_kick_env;
   logic [ENV_W-1:0]    w_snare_env;
   logic                w_env_zero;
   logic                w_advance;
   logic                w_decay;
   logic                w_enter_fade;

   assign w_env_zero   = (w_kick_env == '0) && (w_snare_env == '0);
   // A frame counts only in PLAY with no start/stop competing for the cycle;
   // a stop freezes songpos and arpidx where they are.
   assign w_advance    = (r_state == S_PLAY) && frame_tick && !start && !stop;
   assign w_decay      = frame_tick && !start &&
                         ((r_state == S_PLAY) || (r_state == S_FADE));
   assign w_enter_fade = (r_state == S_PLAY) && stop && !start;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state decode; start always wins and restarts playback.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_PLAY;
         S_PLAY:  if (start) w_state_next = S_PLAY;
                  else if (stop) w_state_next = S_FADE;
         S_FADE:  if (start) w_state_next = S_PLAY;
                  else if (w_env_zero) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Frame/arpeggio counters, song position and the step strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fcnt        <= '0;
         r_acnt        <= '0;
         r_songpos     <= '0;
         r_arpidx      <= 1'b0;
         r_step_strobe <= 1'b0;
      end else begin
         r_step_strobe <= 1'b0;
         if (start) begin
            r_fcnt        <= '0;
            r_acnt        <= '0;
            r_songpos     <= '0;
            r_arpidx      <= 1'b0;
            r_step_strobe <= 1'b1;
         end else if (w_advance) begin
            if (r_fcnt == FCNT_LAST) begin
               r_fcnt        <= '0;
               r_step_strobe <= 1'b1;
               r_songpos     <= (r_songpos == 8'hFF) ? LOOP_POS : r_songpos + 8'd1;
            end else begin
               r_fcnt <= r_fcnt + 1'b1;
            end
            if (r_acnt == ACNT_LAST) begin
               r_acnt   <= '0;
               r_arpidx <= ~r_arpidx;
            end else begin
               r_acnt <= r_acnt + 1'b1;
            end
         end
      end
   end

   // Pulse gate latches the ROM mask at each step and mutes on entering FADE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             r_pulse_gate <= 1'b0;
      else if (w_enter_fade)  r_pulse_gate <= 1'b0;
      else if (r_step_strobe) r_pulse_gate <= pulse_in;
   end

   song_sequencer_trig_env #(.ENV_W(ENV_W)) u_kick_env (
      .clk     (clk),
      .rst_n   (rst_n),
      .trig    (kick_in),
      .load_en (r_step_strobe),
      .dec_en  (w_decay),
      .env     (w_kick_env)
   );

   song_sequencer_trig_env #(.ENV_W(ENV_W)) u_snare_env (
      .clk     (clk),
      .rst_n   (rst_n),
      .trig    (snare_in),
      .load_en (r_step_strobe),
      .dec_en  (w_decay),
      .env     (w_snare_env)
   );

   assign songpos     = r_songpos;
   assign arpidx      = r_arpidx;
   assign step_strobe = r_step_strobe;
   assign kick_env    = w_kick_env;
   assign snare_env   = w_snare_env;
   assign pulse_gate  = r_pulse_gate;
   assign playing     = (r_state == S_PLAY);

endmodule
